pq_heap: RTL and testbench
==========================

# pq_heap

Parametrised binary-heap priority queue engine: the next-generation heap core behind the KCPSM6 port-mapped heap peripheral. It adds configurable key width, depth and min/max ordering, a single-command replace-top operation, full/error reporting, and an optional sticky completion flag that firmware clears with an ack strobe. Storage is a register array indexed 1..CAP; sift-up and sift-down run one compare/swap per clock.

## Interface
- DATA_W, 8, key width in bits, compared as unsigned.
- ADDR_W, 4, index width; capacity CAP = 2^ADDR_W − 1 entries.
- MAX_HEAP, 0: 0 = min-heap, with the smallest key on top; 1 = max-heap.

- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- push  in  1  insert command, sampled only in IDLE
- pop  in  1  remove-top command, sampled only in IDLE
- din  in  DATA_W  key for push or replace
- ack  in  1  clears done_flag (see Configuration)
- dout  out  DATA_W  top key; 0 when empty
- size  out  ADDR_W  current entry count, 0..CAP
- valid  out  1  size != 0 and not busy
- full  out  1  size == CAP
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when an operation completes
- err  out  1  one-cycle pulse when a command is rejected
- done_flag  out  1  sticky completion flag

## Operation
- States: IDLE, UP (sift-up), DOWN (sift-down).
- "better(a,b)": a<b for min-heap, a>b for max-heap. Equal keys never swap.
- Command decode in IDLE, by priority:
  - push&pop, size≥1: replace — mem[1]←din, size unchanged, idx←1, go to DOWN.
  - push&pop, size=0: treated as push.
  - push, !full: mem[size+1]←din, size←size+1, idx←size+1, go to UP.
  - push, full: rejected; err pulse; no state change.
  - pop, size≥1: mem[1]←mem[size], size←size−1, idx←1, go to DOWN. If the new size is 0, go straight to IDLE with done.
  - pop, size=0: rejected; err pulse.
- UP, each cycle:
  - If idx==1 or !better(mem[idx],mem[idx>>1]): go to IDLE and pulse done.
  - Else swap the two entries and set idx←idx>>1.
- DOWN, each cycle:
  - Child l=2·idx, r=l+1; a child is valid only if its index ≤ size.
  - Best child c = r if r valid and better(mem[r],mem[l]), else l.
  - If l is invalid or !better(mem[c],mem[idx]): go to IDLE and pulse done.
  - Else swap the entries and set idx←c.
- Commands arriving while busy are ignored and pulse err.
- dout = mem[1] when size≠0, else 0. dout is meaningful only while valid.
- Memory contents are not reset; dout and valid gating hide them.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, size=0, done=0, err=0, done_flag=0, idx=0. Outputs: dout=0, valid=0, full=0, busy=0.
- Reset asserted mid-operation aborts the operation; the heap comes out of reset empty.
- Accept edge E0: busy rises after E0.
- An operation performing k swaps finishes at edge E0+k+1. done and valid rise after that edge, and busy falls.
- A pop that empties the heap completes at E0: done after E0, busy never rises.
- Worst-case latency: ADDR_W cycles from accept to done.
- err is registered and rises the cycle after the rejected command.
- size and full update at E0. dout reflects the final ordering only once busy=0.

## Configuration
- PQ_HEAP_STICKY_DONE_EN defined:
  - done_flag sets on done and clears on ack.
  - If done and ack coincide, set wins.
- Undefined: done_flag is tied to 0 and ack is ignored.

## Test plan
- Min-heap, push 5,3,8,1 (wait for done each time) → size=4, dout=1. Then 4 pops → dout before each pop reads 1,3,5,8; afterwards valid=0, size=0, dout=0.
- Pop on empty → err high for 1 cycle, size stays 0, done never pulses. Push 15 keys (CAP=15), then push 0x42 → full=1, err pulse, size=15, dout unchanged.
- Heap {2,4,6}: push&pop with din=9 → size stays 3, dout=4 after done. Push&pop when empty with din=7 → size=1, dout=7.
- MAX_HEAP=1, push 10,200,55 → dout=200. Push, then assert pop while busy → err pulse and command ignored.
- Push 15 descending keys 15..1 into min-heap → final push takes 4 cycles to done, dout=1. Assert reset during a sift → size=0, busy=0, valid=0 immediately.
- With PQ_HEAP_STICKY_DONE_EN defined: done_flag=1 after a push and holds until ack; ack coincident with done leaves it at 1. Without the macro: done_flag stays 0.

Source files
------------

// File: rtl/pq_heap.sv
// pq_heap: binary-heap priority queue with one compare/swap per clock.
// Optional sticky completion flag: define PQ_HEAP_STICKY_DONE_EN.
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : pq_heap
// Purpose : min/max binary heap over a 1-based register array
// Rev     : 1.0
// ---------------------------------------------------------------------------
module pq_heap #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int MAX_HEAP = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  input  logic              ack,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] size,
  output logic              valid,
  output logic              full,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              done_flag
);

  localparam int CAP = (1 << ADDR_W) - 1;
  localparam logic [ADDR_W-1:0] C_CAP = ADDR_W'(CAP);
  localparam logic [ADDR_W-1:0] C_ONE = ADDR_W'(1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] size_q, size_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  // Entry 0 is never used so that child/parent indices map directly.
  logic [DATA_W-1:0] mem_q [0:CAP];
  logic [DATA_W-1:0] mem_d [0:CAP];

  function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (MAX_HEAP != 0) ? (a > b) : (a < b);
  endfunction

  logic [ADDR_W-1:0] parent;
  logic [ADDR_W:0]   lft, rgt;
  logic              l_ok, r_ok;
  logic [ADDR_W-1:0] l_a, r_a, c_a;

  always_comb begin
    parent = idx_q >> 1;
    lft    = {idx_q, 1'b0};
    rgt    = {idx_q, 1'b1};
    l_ok   = lft <= {1'b0, size_q};
    r_ok   = rgt <= {1'b0, size_q};
    l_a    = lft[ADDR_W-1:0];
    r_a    = rgt[ADDR_W-1:0];
    c_a    = (r_ok && better(mem_q[r_a], mem_q[l_a])) ? r_a : l_a;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mem_d   = mem_q;
    case (state_q)
      S_IDLE: begin
        if (push && pop && (size_q != '0)) begin
          mem_d[C_ONE] = din;
          idx_d        = C_ONE;
          state_d      = S_DOWN;
        end else if (push) begin
          if (size_q == C_CAP) begin
            err_d = 1'b1;
          end else begin
            mem_d[size_q + C_ONE] = din;
            size_d  = size_q + C_ONE;
            idx_d   = size_q + C_ONE;
            state_d = S_UP;
          end
        end else if (pop) begin
          if (size_q == '0) begin
            err_d = 1'b1;
          end else begin
            mem_d[C_ONE] = mem_q[size_q];
            size_d       = size_q - C_ONE;
            idx_d        = C_ONE;
            if (size_q == C_ONE) done_d  = 1'b1;
            else                 state_d = S_DOWN;
          end
        end
      end
      S_UP: begin
        err_d = push | pop;
        if ((idx_q == C_ONE) || !better(mem_q[idx_q], mem_q[parent])) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          mem_d[idx_q]  = mem_q[parent];
          mem_d[parent] = mem_q[idx_q];
          idx_d         = parent;
        end
      end
      S_DOWN: begin
        err_d = push | pop;
        if (!l_ok || !better(mem_q[c_a], mem_q[idx_q])) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          mem_d[idx_q] = mem_q[c_a];
          mem_d[c_a]   = mem_q[idx_q];
          idx_d        = c_a;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      size_q <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      size_q <= size_d;
      idx_q  <= idx_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  // Storage is deliberately left out of reset; size gating hides stale data.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    dout  = (size_q != '0) ? mem_q[C_ONE] : '0;
    size  = size_q;
    valid = (size_q != '0) && (state_q == S_IDLE);
    full  = (size_q == C_CAP);
    busy  = (state_q != S_IDLE);
    done  = done_q;
    err   = err_q;
  end

`ifdef PQ_HEAP_STICKY_DONE_EN
  logic flag_q, flag_d;

  always_comb begin
    flag_d = flag_q;
    if (done_q)   flag_d = 1'b1;
    else if (ack) flag_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flag_q <= 1'b0;
    else        flag_q <= flag_d;
  end

  assign done_flag = flag_q;
`else
  logic unused_ack;
  assign unused_ack = ack;
  assign done_flag  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pq_heap.sv
// tb_pq_heap: directed and random checks of a min-heap and a max-heap instance
// against a flat-array priority-queue model.
`default_nettype none
module tb_pq_heap;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int CAP = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          push_s [2];
  logic          pop_s  [2];
  logic          ack_s  [2];
  logic [DW-1:0] din_s  [2];
  logic [DW-1:0] dout_s [2];
  logic [AW-1:0] size_s [2];
  logic          valid_s[2];
  logic          full_s [2];
  logic          busy_s [2];
  logic          done_s [2];
  logic          err_s  [2];
  logic          flag_s [2];

  pq_heap #(.DATA_W(DW), .ADDR_W(AW), .MAX_HEAP(0)) u_min (
    .clk(clk), .reset(rst_n), .push(push_s[0]), .pop(pop_s[0]), .din(din_s[0]),
    .ack(ack_s[0]), .dout(dout_s[0]), .size(size_s[0]), .valid(valid_s[0]),
    .full(full_s[0]), .busy(busy_s[0]), .done(done_s[0]), .err(err_s[0]),
    .done_flag(flag_s[0]));

  pq_heap #(.DATA_W(DW), .ADDR_W(AW), .MAX_HEAP(1)) u_max (
    .clk(clk), .reset(rst_n), .push(push_s[1]), .pop(pop_s[1]), .din(din_s[1]),
    .ack(ack_s[1]), .dout(dout_s[1]), .size(size_s[1]), .valid(valid_s[1]),
    .full(full_s[1]), .busy(busy_s[1]), .done(done_s[1]), .err(err_s[1]),
    .done_flag(flag_s[1]));

  int checks   = 0;
  int failures = 0;
  int mk [2][CAP];
  int mn [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Unordered bag of keys; the top is found by a linear scan.
  function automatic int mbest(input int s);
    int bi = 0;
    for (int i = 1; i < mn[s]; i++)
      if ((s == 1) ? (mk[s][i] > mk[s][bi]) : (mk[s][i] < mk[s][bi])) bi = i;
    return bi;
  endfunction

  function automatic int mtop(input int s);
    return (mn[s] == 0) ? 0 : mk[s][mbest(s)];
  endfunction

  function automatic void mremove(input int s);
    int bi = mbest(s);
    mk[s][bi] = mk[s][mn[s]-1];
    mn[s]--;
  endfunction

  function automatic void madd(input int s, input int d);
    mk[s][mn[s]] = d;
    mn[s]++;
  endfunction

  task automatic run_op(input int s, input bit p, input bit o, input int d, output int lat);
    int  sz;
    int  nsz;
    bit  rej;
    bit  to_empty;
    sz       = mn[s];
    lat      = -1;
    rej      = (p && !o && sz == CAP) || (o && !p && sz == 0);
    to_empty = o && !p && sz == 1;
    if (!rej) begin
      if (p && o && sz >= 1) begin mremove(s); madd(s, d); end
      else if (p)            madd(s, d);
      else                   mremove(s);
    end
    nsz = mn[s];
    @(negedge clk);
    push_s[s] = p; pop_s[s] = o; din_s[s] = d[DW-1:0];
    @(posedge clk); #1;
    push_s[s] = 1'b0; pop_s[s] = 1'b0;
    check("err_e0", err_s[s], rej);
    check("size_e0", size_s[s], nsz);
    check("full_e0", full_s[s], nsz == CAP);
    if (rej) begin
      check("done_rej", done_s[s], 0);
      @(posedge clk); #1;
      check("err_clear", err_s[s], 0);
      check("done_rej2", done_s[s], 0);
      check("dout_rej", dout_s[s], mtop(s));
      return;
    end
    check("busy_e0", busy_s[s], !to_empty);
    lat = 0;
    while (!done_s[s] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_seen", done_s[s], 1);
    check("busy_end", busy_s[s], 0);
    check("valid_end", valid_s[s], nsz != 0);
    check("dout_end", dout_s[s], mtop(s));
    check("lat_bound", lat <= AW, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      check("rst_size", size_s[s], 0);
      check("rst_dout", dout_s[s], 0);
      check("rst_valid", valid_s[s], 0);
      check("rst_full", full_s[s], 0);
      check("rst_busy", busy_s[s], 0);
      check("rst_done", done_s[s], 0);
      check("rst_err", err_s[s], 0);
      check("rst_flag", flag_s[s], 0);
    end
    mn[0] = 0; mn[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    int ord[4];
    int wd;
    ord = '{1, 3, 5, 8};
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      push_s[s] = 0; pop_s[s] = 0; ack_s[s] = 0; din_s[s] = '0;
    end
    mn[0] = 0; mn[1] = 0;
    do_reset();

    run_op(0, 1, 0, 5, lat); run_op(0, 1, 0, 3, lat);
    run_op(0, 1, 0, 8, lat); run_op(0, 1, 0, 1, lat);
    check("min4_size", size_s[0], 4);
    check("min4_top", dout_s[0], 1);
    for (int i = 0; i < 4; i++) begin
      check("pop_order", dout_s[0], ord[i]);
      run_op(0, 0, 1, 0, lat);
    end
    check("empty_valid", valid_s[0], 0);
    check("empty_dout", dout_s[0], 0);

    run_op(0, 0, 1, 0, lat);
    for (int i = 0; i < CAP; i++) run_op(0, 1, 0, $urandom_range(0, 255), lat);
    check("full_flag", full_s[0], 1);
    run_op(0, 1, 0, 8'h42, lat);

    for (int i = 0; i < 80; i++) begin
      int k = $urandom_range(0, 3);
      run_op(0, k != 2, k >= 2, $urandom_range(0, 255), lat);
    end
    while (mn[0] > 0) run_op(0, 0, 1, 0, lat);

    run_op(0, 1, 0, 2, lat); run_op(0, 1, 0, 4, lat); run_op(0, 1, 0, 6, lat);
    run_op(0, 1, 1, 9, lat);
    check("repl_size", size_s[0], 3);
    check("repl_top", dout_s[0], 4);
    while (mn[0] > 0) run_op(0, 0, 1, 0, lat);
    run_op(0, 1, 1, 7, lat);
    check("repl_empty_size", size_s[0], 1);
    check("repl_empty_top", dout_s[0], 7);

    run_op(1, 1, 0, 10, lat); run_op(1, 1, 0, 200, lat); run_op(1, 1, 0, 55, lat);
    check("max_top", dout_s[1], 200);
    @(negedge clk);
    push_s[1] = 1; din_s[1] = 8'd30;
    @(posedge clk); #1;
    push_s[1] = 0;
    check("busy_push", busy_s[1], 1);
    @(negedge clk);
    pop_s[1] = 1;
    @(posedge clk); #1;
    pop_s[1] = 0;
    check("err_busy", err_s[1], 1);
    madd(1, 30);
    wd = 0;
    while (!done_s[1] && wd < 20) begin @(posedge clk); #1; wd++; end
    check("busy_done", done_s[1], 1);
    check("busy_size", size_s[1], 4);
    check("busy_top", dout_s[1], 200);
    for (int i = 0; i < 40; i++) begin
      int k = $urandom_range(0, 3);
      run_op(1, k != 2, k >= 2, $urandom_range(0, 255), lat);
    end

    do_reset();
    for (int k = 15; k >= 1; k--) run_op(0, 1, 0, k, lat);
    check("desc_lat", lat, 4);
    check("desc_top", dout_s[0], 1);
    run_op(0, 1, 0, 8'h42, lat);
    @(negedge clk);
    pop_s[0] = 1;
    @(posedge clk); #1;
    pop_s[0] = 0;
    check("sift_busy", busy_s[0], 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_size", size_s[0], 0);
    check("abort_busy", busy_s[0], 0);
    check("abort_valid", valid_s[0], 0);
    check("abort_dout", dout_s[0], 0);
    mn[0] = 0; mn[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef PQ_HEAP_STICKY_DONE_EN
    run_op(0, 1, 0, 7, lat);
    @(posedge clk); #1;
    check("flag_set", flag_s[0], 1);
    repeat (3) @(posedge clk);
    #1;
    check("flag_hold", flag_s[0], 1);
    @(negedge clk); ack_s[0] = 1;
    @(posedge clk); #1; ack_s[0] = 0;
    check("flag_ack", flag_s[0], 0);
    run_op(0, 1, 0, 3, lat);
    ack_s[0] = 1;
    @(posedge clk); #1; ack_s[0] = 0;
    check("flag_set_wins", flag_s[0], 1);
`else
    run_op(0, 1, 0, 7, lat);
    @(negedge clk); ack_s[0] = 1;
    @(posedge clk); #1; ack_s[0] = 0;
    check("flag_off", flag_s[0], 0);
    run_op(0, 1, 0, 3, lat);
    @(posedge clk); #1;
    check("flag_off2", flag_s[0], 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
